complex_divider: RTL and testbench
==================================

Name: complex_divider

Overview:
- Sequential complex divider: computes Q = (num_re + j·num_im) / (den_re + j·den_im).
- Inverse companion of the registered 8x8 complex multiplier. It recovers one operand from a product and the other operand.
- Numerator width matches the multiplier's 16-bit re/im outputs. Denominator width matches its N-bit unsigned operands.
- One shared multiplier plus a bit-serial restoring divider. Fixed latency, start/busy/done handshake.

Parameters:
- N, 8: width of den_re/den_im (unsigned).
- W, 16: width of num_re/num_im and q_re/q_im (two's-complement signed).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted on a rising edge where start=1 and busy=0.
- num_re  input  W  numerator real part, signed.
- num_im  input  W  numerator imaginary part, signed.
- den_re  input  N  denominator real part, unsigned.
- den_im  input  N  denominator imaginary part, unsigned.
- busy  output  1  high from the accepting edge until the result edge.
- done  output  1  one-cycle pulse; results valid.
- q_re  output  W  quotient real part, signed, truncated toward zero.
- q_im  output  W  quotient imaginary part, signed, truncated toward zero.
- dz  output  1  divide-by-zero flag for the current result.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; busy=0, done=0, q_re=0, q_im=0, dz=0; internal registers cleared. Any in-flight operation is discarded and produces no done.
- Math, with a=num_re, b=num_im, c=den_re, d=den_im:
  - M = c²+d², unsigned, 2N+1 bits.
  - Pre = a·c + b·d; Pim = b·c − a·d. Signed; |P| < 2^(W+N).
  - q_re = trunc(Pre/M), q_im = trunc(Pim/M), truncation toward zero (C-style signed division).
- Result range: |q| ≤ 2^(W−1)(c+d)/(c²+d²) ≤ 2^(W−1), so the result always fits W signed bits. No saturation logic; the bench asserts q in range.
- States: IDLE → MUL → DIV → FIN → IDLE.
- IDLE: busy=0. On an accepting edge, latch a, b, c, d into operand registers and go to MUL. Inputs are don't-care afterwards.
- MUL: exactly 6 cycles, one product per cycle on a single shared signed (W+1)x(N+1) multiplier.
  - Product order: c·c, d·d, a·c, b·d, b·c, a·d.
  - Each product is accumulated into M, Pre or Pim.
- DIV: exactly W+N cycles.
  - Two parallel restoring dividers operate on |Pre| and |Pim| by M, MSB first, one quotient bit per cycle.
  - Signs of Pre and Pim are held in flags.
- FIN: 1 cycle. Apply signs (negate the magnitude quotient if P < 0), then register q_re, q_im and dz.
  - Registered done=1 and busy=0 appear after this edge.
- Latency: the accepting edge is E0. Outputs update on edge E(6+W+N+1), which is E31 for the defaults. done is high for exactly the one cycle following that edge.
- Back-to-back: start=1 during the done cycle is accepted, giving a throughput of one result per 32 cycles at the defaults.
- start while busy=1: ignored, no queuing; the current operation is unaffected.
- Output hold: q_re, q_im and dz hold their values between done pulses. They change only on the FIN edge or on reset.
- Divide by zero (c=d=0):
  - Full latency is still consumed.
  - Result is q_re=0, q_im=0, dz=1.
  - dz is cleared by the next non-zero-denominator result.
- Zero numerator: q=0, dz=0.

Test Plan:
- Basic: num=6+j8, den=3+j4, start at E0 → done in the cycle after E31, busy high for exactly 31 cycles, q_re=2, q_im=0, dz=0.
- Signed: num=−100+j50, den=2+j1 → q_re=−30, q_im=40. Back-to-back: pulse start in the done cycle with num=−7+j0, den=2+j0 → second result −3+j0 (truncation toward zero, not −4).
- Extremes: num=−32768−j32768, den=1+j1 → q_re=−32768, q_im=0. Num=32767−j32768, den=255+j255 → q_re=0, q_im=−128 (−16711425/130050 truncated).
- Divide by zero: num=1234+j5, den=0+j0 → done at the same latency, q=0+j0, dz=1. Follow with num=10+j0, den=5+j0 → q=2+j0, dz=0.
- Busy ignore: start with num=6+j8, den=3+j4; at E10 pulse start with num=99+j99, den=1+j0 → single done only, q=2+j0. Outputs hold across 20 idle cycles.
- Reset mid-op: start at E0; drop rst_n asynchronously mid-cycle between E15 and E16 → busy, done, q and dz go to 0 immediately, and no done follows after release. A fresh start then completes normally with 31-cycle latency.

Source files
------------

// File: rtl/complex_divider_if.sv
// Handshake and data bundle for the sequential complex divider.
// start is sampled on a rising edge and is taken only while busy=0; busy stays
// high from that accepting edge until the result edge; done is a one-cycle pulse
// marking q_re/q_im/dz valid, and those outputs hold until the next result.
interface complex_divider_if #(
    parameter int N = 8,
    parameter int W = 16
);
    logic                start;
    logic signed [W-1:0] num_re;
    logic signed [W-1:0] num_im;
    logic [N-1:0]        den_re;
    logic [N-1:0]        den_im;
    logic                busy;
    logic                done;
    logic signed [W-1:0] q_re;
    logic signed [W-1:0] q_im;
    logic                dz;
    logic [1:0]          dbg_state;

    modport master (
        output start, num_re, num_im, den_re, den_im,
        input  busy, done, q_re, q_im, dz, dbg_state
    );

    modport slave (
        input  start, num_re, num_im, den_re, den_im,
        output busy, done, q_re, q_im, dz, dbg_state
    );
endinterface

// File: rtl/complex_divider.sv
// Sequential complex divider: Q = (a + jb) / (c + jd), truncated toward zero.
// Six cycles of a single shared signed multiplier build M = c^2 + d^2,
// Pre = ac + bd and Pim = bc - ad; two restoring dividers then produce one
// magnitude quotient bit per cycle over W+N cycles; a final cycle applies the
// signs and registers the result. Fixed latency of 6 + W + N + 1 edges.
module complex_divider #(
    parameter int N = 8,
    parameter int W = 16
) (
    input logic               clk,
    input logic               rst_n,
    complex_divider_if.slave  bus
);

    localparam int MW = 2 * N + 1;          // c^2 + d^2
    localparam int PW = W + N + 1;          // signed Pre / Pim, |P| < 2^(W+N)
    localparam int DW = W + N;              // magnitude of P, also divide steps
    localparam int CW = $clog2(W + N);      // step counter

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [W-1:0]  a_q, a_d, b_q, b_d;
    logic [N-1:0]         c_q, c_d, d_q, d_d;
    logic [MW-1:0]        m_q, m_d;
    logic signed [PW-1:0] pre_q, pre_d, pim_q, pim_d;
    logic [DW-1:0]        dvd_re_q, dvd_re_d, dvd_im_q, dvd_im_d;
    logic [MW-1:0]        rem_re_q, rem_re_d, rem_im_q, rem_im_d;
    logic [W-1:0]         quo_re_q, quo_re_d, quo_im_q, quo_im_d;
    logic                 neg_re_q, neg_re_d, neg_im_q, neg_im_d;
    logic                 busy_q, busy_d, done_q, done_d, dz_q, dz_d;
    logic signed [W-1:0]  q_re_q, q_re_d, q_im_q, q_im_d;

    logic signed [W:0]    mul_a;
    logic signed [N:0]    mul_b;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] pim_fin;
    logic [MW:0]          step_re, step_im;

    // Magnitude of a signed partial product; the most negative value never occurs.
    function automatic logic [DW-1:0] mag(input logic signed [PW-1:0] x);
        return DW'(x[PW-1] ? -x : x);
    endfunction

    // One restoring-division step: returns {quotient bit, next remainder}.
    function automatic logic [MW:0] div_step(input logic [MW-1:0] rem,
                                             input logic          din,
                                             input logic [MW-1:0] m);
        logic [MW:0] sh;
        sh = {rem, din};
        if (sh >= {1'b0, m}) begin
            return {1'b1, MW'(sh - {1'b0, m})};
        end
        return {1'b0, sh[MW-1:0]};
    endfunction

    // Shared multiplier: operand pair chosen by the MUL step index.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (cnt_q[2:0])
            3'd0: begin mul_a = (W+1)'(c_q);    mul_b = (N+1)'(c_q); end
            3'd1: begin mul_a = (W+1)'(d_q);    mul_b = (N+1)'(d_q); end
            3'd2: begin mul_a = {a_q[W-1], a_q}; mul_b = (N+1)'(c_q); end
            3'd3: begin mul_a = {b_q[W-1], b_q}; mul_b = (N+1)'(d_q); end
            3'd4: begin mul_a = {b_q[W-1], b_q}; mul_b = (N+1)'(c_q); end
            3'd5: begin mul_a = {a_q[W-1], a_q}; mul_b = (N+1)'(d_q); end
            default: begin mul_a = '0; mul_b = '0; end
        endcase
        prod    = PW'(mul_a) * PW'(mul_b);
        pim_fin = pim_q - prod;
        step_re = div_step(rem_re_q, dvd_re_q[DW-1], m_q);
        step_im = div_step(rem_im_q, dvd_im_q[DW-1], m_q);
    end

    // Next-state and datapath update for the IDLE -> MUL -> DIV -> FIN sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        d_d      = d_q;
        m_d      = m_q;
        pre_d    = pre_q;
        pim_d    = pim_q;
        dvd_re_d = dvd_re_q;
        dvd_im_d = dvd_im_q;
        rem_re_d = rem_re_q;
        rem_im_d = rem_im_q;
        quo_re_d = quo_re_q;
        quo_im_d = quo_im_q;
        neg_re_d = neg_re_q;
        neg_im_d = neg_im_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dz_d     = dz_q;
        q_re_d   = q_re_q;
        q_im_d   = q_im_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.num_re;
                    b_d     = bus.num_im;
                    c_d     = bus.den_re;
                    d_d     = bus.den_im;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                cnt_d = cnt_q + 1'b1;
                case (cnt_q[2:0])
                    3'd0: m_d   = prod[MW-1:0];
                    3'd1: m_d   = m_q + prod[MW-1:0];
                    3'd2: pre_d = prod;
                    3'd3: pre_d = pre_q + prod;
                    3'd4: pim_d = prod;
                    default: begin
                        // Last product: Pim is complete here, so seed both dividers.
                        pim_d    = pim_fin;
                        dvd_re_d = mag(pre_q);
                        dvd_im_d = mag(pim_fin);
                        neg_re_d = pre_q[PW-1];
                        neg_im_d = pim_fin[PW-1];
                        rem_re_d = '0;
                        rem_im_d = '0;
                        quo_re_d = '0;
                        quo_im_d = '0;
                        cnt_d    = '0;
                        state_d  = S_DIV;
                    end
                endcase
            end
            S_DIV: begin
                dvd_re_d = dvd_re_q << 1;
                dvd_im_d = dvd_im_q << 1;
                rem_re_d = step_re[MW-1:0];
                rem_im_d = step_im[MW-1:0];
                quo_re_d = {quo_re_q[W-2:0], step_re[MW]};
                quo_im_d = {quo_im_q[W-2:0], step_im[MW]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = S_FIN;
                end
            end
            default: begin
                // FIN: a zero denominator reports zero with the dz flag.
                if (m_q == '0) begin
                    dz_d   = 1'b1;
                    q_re_d = '0;
                    q_im_d = '0;
                end else begin
                    dz_d   = 1'b0;
                    q_re_d = neg_re_q ? -quo_re_q : quo_re_q;
                    q_im_d = neg_im_q ? -quo_im_q : quo_im_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; asynchronous reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            m_q      <= '0;
            pre_q    <= '0;
            pim_q    <= '0;
            dvd_re_q <= '0;
            dvd_im_q <= '0;
            rem_re_q <= '0;
            rem_im_q <= '0;
            quo_re_q <= '0;
            quo_im_q <= '0;
            neg_re_q <= 1'b0;
            neg_im_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            q_re_q   <= '0;
            q_im_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            d_q      <= d_d;
            m_q      <= m_d;
            pre_q    <= pre_d;
            pim_q    <= pim_d;
            dvd_re_q <= dvd_re_d;
            dvd_im_q <= dvd_im_d;
            rem_re_q <= rem_re_d;
            rem_im_q <= rem_im_d;
            quo_re_q <= quo_re_d;
            quo_im_q <= quo_im_d;
            neg_re_q <= neg_re_d;
            neg_im_q <= neg_im_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
            q_re_q   <= q_re_d;
            q_im_q   <= q_im_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dz        = dz_q;
    assign bus.q_re      = q_re_q;
    assign bus.q_im      = q_im_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_complex_divider.sv
// Directed bench for complex_divider: latency, busy window, signed truncation,
// extremes, divide by zero, ignored start while busy, output hold, and reset
// in the middle of an operation.
module tb_complex_divider;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    complex_divider_if #(.N(8), .W(16)) bus ();

    complex_divider #(.N(8), .W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Present an operation and step to 1 time unit after its accepting edge.
    task automatic start_op(input int a, input int b, input int c, input int d);
        bus.start  = 1'b1;
        bus.num_re = 16'(a);
        bus.num_im = 16'(b);
        bus.den_re = 8'(c);
        bus.den_im = 8'(d);
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.num_re = 16'($urandom);
        bus.num_im = 16'($urandom);
        bus.den_re = 8'($urandom);
        bus.den_im = 8'($urandom);
    endtask

    // Called k0 edges after the accepting edge (busy already high through E_k0).
    task automatic wait_done(input string tag, input int k0, input int exp_re,
                             input int exp_im, input int exp_dz);
        int  k      = k0;
        int  busy_n = k0 + 1;
        bit  seen   = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            #1;
            k++;
            if (bus.done) seen = 1'b1;
            else if (bus.busy) busy_n++;
        end
        check({tag, " latency"}, k, 31);
        check({tag, " busy_cycles"}, busy_n, 31);
        check({tag, " busy_at_done"}, bus.busy, 0);
        check({tag, " q_re"}, bus.q_re, exp_re);
        check({tag, " q_im"}, bus.q_im, exp_im);
        check({tag, " dz"}, bus.dz, exp_dz);
    endtask

    task automatic check_pulse(input string tag);
        @(posedge clk);
        #1;
        check({tag, " done_width"}, bus.done, 0);
    endtask

    initial begin
        int dn;
        int bad;

        bus.start  = 1'b0;
        bus.num_re = '0;
        bus.num_im = '0;
        bus.den_re = '0;
        bus.den_im = '0;

        // Reset state
        #12;
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst q_re", bus.q_re, 0);
        check("rst q_im", bus.q_im, 0);
        check("rst dz", bus.dz, 0);
        check("rst state", bus.dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic: (6+j8)/(3+j4) = 2
        start_op(6, 8, 3, 4);
        check("basic busy_after_accept", bus.busy, 1);
        check("basic state_mul", bus.dbg_state, 1);
        wait_done("basic", 0, 2, 0, 0);
        check_pulse("basic");

        // Signed, then back-to-back start in the done cycle
        start_op(-100, 50, 2, 1);
        wait_done("signed", 0, -30, 40, 0);
        start_op(-7, 0, 2, 0);
        wait_done("b2b_trunc", 0, -3, 0, 0);
        check_pulse("b2b_trunc");

        // Start while busy is ignored
        start_op(6, 8, 3, 4);
        repeat (9) @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.num_re = 16'sd99;
        bus.num_im = 16'sd99;
        bus.den_re = 8'd1;
        bus.den_im = 8'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("ignore", 10, 2, 0, 0);
        dn  = 0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dn++;
            if (i < 20 && (bus.q_re !== 16'sd2 || bus.q_im !== 16'sd0 || bus.dz !== 1'b0)) bad++;
        end
        check("ignore extra_done", dn, 0);
        check("hold changed_cycles", bad, 0);

        // Extremes
        start_op(-32768, -32768, 1, 1);
        wait_done("ext_neg", 0, -32768, 0, 0);
        check_pulse("ext_neg");
        start_op(32767, -32768, 255, 255);
        wait_done("ext_255", 0, 0, -128, 0);
        check_pulse("ext_255");

        // Divide by zero, then a normal result clears dz
        start_op(1234, 5, 0, 0);
        wait_done("dz", 0, 0, 0, 1);
        check_pulse("dz");
        start_op(10, 0, 5, 0);
        wait_done("dz_clear", 0, 2, 0, 0);
        check_pulse("dz_clear");

        // Reset mid-operation, between E15 and E16
        start_op(6, 8, 3, 4);
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst busy", bus.busy, 0);
        check("midrst done", bus.done, 0);
        check("midrst q_re", bus.q_re, 0);
        check("midrst q_im", bus.q_im, 0);
        check("midrst dz", bus.dz, 0);
        check("midrst state", bus.dbg_state, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dn++;
        end
        check("midrst no_done", dn, 0);
        start_op(-100, 50, 2, 1);
        wait_done("after_rst", 0, -30, 40, 0);
        check_pulse("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
